// File: rtl/spi_pkg.sv
// Shared definitions for the M25P16 SPI master and the flash read/write controllers that feed it.
package spi_pkg;

    localparam int SCK_DIV_DEFAULT = 4;
    localparam int CS_HOLD_DEFAULT = 4;

    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_READ = 8'h03;

    localparam logic [6:0] ST_IDLE  = 7'b000_0001;
    localparam logic [6:0] ST_SETUP = 7'b000_0010;
    localparam logic [6:0] ST_LOAD  = 7'b000_0100;
    localparam logic [6:0] ST_SHIFT = 7'b000_1000;
    localparam logic [6:0] ST_DONE  = 7'b001_0000;
    localparam logic [6:0] ST_GAP   = 7'b010_0000;
    localparam logic [6:0] ST_CSH   = 7'b100_0000;

    typedef enum logic [6:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE,
        GAP   = ST_GAP,
        CSH   = ST_CSH
    } spi_state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        if (max_val < 1) begin
            w = 1;
        end else begin
            w = $clog2(max_val + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-level request/response bus between a flash controller (master) and the SPI engine (slave).
interface spi_master_if;

    logic       trans_req;
    logic [7:0] tx_din;
    logic [7:0] rx_dout;
    logic       trans_done;

    modport master (
        output trans_req,
        output tx_din,
        input  rx_dout,
        input  trans_done
    );

    modport slave (
        input  trans_req,
        input  tx_din,
        output rx_dout,
        output trans_done
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK timing for one byte: divider phase strobes plus a bit counter flagging the final falling edge.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int SCK_DIV = SCK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sck_rise,
    output logic sck_fall,
    output logic last_fall
);

    localparam int DW = cnt_width(SCK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(SCK_DIV / 2 - 1);
    localparam logic [DW-1:0] FULL_LAST = DW'(SCK_DIV - 1);

    logic [DW-1:0] div_cnt_r;
    logic [2:0]    bit_cnt_r;

    // Phase within the current SCK period; parked at zero outside the shift window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (!en || (div_cnt_r == FULL_LAST)) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1'b1);
        end
    end

    // Completed bit periods of the current byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= 3'd0;
        end else if (clr) begin
            bit_cnt_r <= 3'd0;
        end else if (sck_fall) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign sck_rise  = en && (div_cnt_r == HALF_LAST);
    assign sck_fall  = en && (div_cnt_r == FULL_LAST);
    assign last_fall = sck_fall && (bit_cnt_r == 3'd7);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 byte engine for the M25P16: CS framing driven by trans_req, MSB-first shifting,
// one trans_done pulse per byte.
module spi_master
    import spi_pkg::*;
#(
    parameter int SCK_DIV = SCK_DIV_DEFAULT,
    parameter int CS_HOLD = CS_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus,
    output logic         spi_sclk,
    output logic         spi_cs_n,
    output logic         spi_mosi,
    input  logic         spi_miso
);

    localparam int HALF = SCK_DIV / 2;
    localparam int CW   = cnt_width((HALF > CS_HOLD) ? HALF : CS_HOLD);
    localparam logic [CW-1:0] SETUP_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CSH_LAST   = CW'(CS_HOLD - 1);

    spi_state_e    state_r;
    spi_state_e    state_s;
    logic [CW-1:0] phase_cnt_r;

    logic [6:0] tx_sr_r;
    logic [6:0] tx_sr_s;
    logic [7:0] rx_sr_r;
    logic [7:0] rx_sr_s;
    logic       sclk_r;
    logic       sclk_s;
    logic       cs_n_r;
    logic       cs_n_s;
    logic       mosi_r;
    logic       mosi_s;
    logic       done_r;
    logic [7:0] rx_dout_r;

    logic sck_rise_s;
    logic sck_fall_s;
    logic last_fall_s;

    spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state_r == SHIFT),
        .clr       (state_r == LOAD),
        .sck_rise  (sck_rise_s),
        .sck_fall  (sck_fall_s),
        .last_fall (last_fall_s)
    );

    // Next-state logic; CSH ignores trans_req so the flash always sees the full deselect time.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.trans_req) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (phase_cnt_r == SETUP_LAST) begin
                    state_s = LOAD;
                end else begin
                    state_s = SETUP;
                end
            end
            LOAD: begin
                state_s = SHIFT;
            end
            SHIFT: begin
                if (last_fall_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = GAP;
            end
            GAP: begin
                if (bus.trans_req) begin
                    state_s = LOAD;
                end else begin
                    state_s = CSH;
                end
            end
            CSH: begin
                if (phase_cnt_r == CSH_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = CSH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the SPI pins and shift registers, registered below so no input reaches a pin directly.
    always_comb begin
        cs_n_s  = cs_n_r;
        sclk_s  = sclk_r;
        mosi_s  = mosi_r;
        tx_sr_s = tx_sr_r;
        rx_sr_s = rx_sr_r;
        case (state_s)
            IDLE, CSH: begin
                cs_n_s = 1'b1;
                sclk_s = 1'b0;
                mosi_s = 1'b0;
            end
            default: begin
                cs_n_s = 1'b0;
            end
        endcase
        if (state_r == LOAD) begin
            tx_sr_s = bus.tx_din[6:0];
            mosi_s  = bus.tx_din[7];
        end else if (sck_rise_s) begin
            sclk_s  = 1'b1;
            rx_sr_s = {rx_sr_r[6:0], spi_miso};
        end else if (sck_fall_s) begin
            sclk_s = 1'b0;
            // MOSI holds the last bit through DONE/GAP so the line is quiet between bytes.
            if (!last_fall_s) begin
                mosi_s  = tx_sr_r[6];
                tx_sr_s = {tx_sr_r[5:0], 1'b0};
            end else begin
                mosi_s  = mosi_r;
                tx_sr_s = tx_sr_r;
            end
        end else begin
            sclk_s = sclk_s;
        end
    end

    // State register and the cycle counter that times SETUP and CSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            phase_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                phase_cnt_r <= {CW{1'b0}};
            end else if ((state_r == SETUP) || (state_r == CSH)) begin
                phase_cnt_r <= phase_cnt_r + CW'(1'b1);
            end else begin
                phase_cnt_r <= phase_cnt_r;
            end
        end
    end

    // Output and shift-register flops; rx_dout and trans_done update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_r    <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            tx_sr_r   <= 7'd0;
            rx_sr_r   <= 8'd0;
            done_r    <= 1'b0;
            rx_dout_r <= 8'd0;
        end else begin
            cs_n_r  <= cs_n_s;
            sclk_r  <= sclk_s;
            mosi_r  <= mosi_s;
            tx_sr_r <= tx_sr_s;
            rx_sr_r <= rx_sr_s;
            done_r  <= (state_s == DONE);
            if (state_s == DONE) begin
                rx_dout_r <= rx_sr_r;
            end else begin
                rx_dout_r <= rx_dout_r;
            end
        end
    end

    assign spi_cs_n       = cs_n_r;
    assign spi_sclk       = sclk_r;
    assign spi_mosi       = mosi_r;
    assign bus.trans_done = done_r;
    assign bus.rx_dout    = rx_dout_r;

endmodule
